// File: rtl/usram_triport_ctrl.sv
// usram_triport_ctrl: 1W/2R store with per-port read latency, collision handling and a clear engine.
module usram_triport_ctrl #(
   parameter int DATA_WIDTH = 18,
   parameter int ADDR_WIDTH = 6,
   parameter int A_LATENCY = 1,
   parameter int B_LATENCY = 1,
   parameter int COLLISION_MODE = 0,
   parameter int CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clr,
   output logic                  init_busy,
   input  logic                  c_we,
   input  logic [ADDR_WIDTH-1:0] c_addr,
   input  logic [DATA_WIDTH-1:0] c_din,
   output logic                  c_drop,
   input  logic                  a_re,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   output logic [DATA_WIDTH-1:0] a_dout,
   output logic                  a_valid,
   output logic                  a_coll,
   input  logic                  b_re,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   output logic [DATA_WIDTH-1:0] b_dout,
   output logic                  b_valid,
   output logic                  b_coll
);
   typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_t;
   state_t state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic wr;
   logic [1:0] re, hit, valid, coll;
   logic [ADDR_WIDTH-1:0] addr [2];
   logic [DATA_WIDTH-1:0] raw [2];
   logic [DATA_WIDTH-1:0] dout [2];
   assign wr = state == S_READY && c_we;
   assign re = {b_re, a_re} & {2{state == S_READY}};
   assign addr[0] = a_addr;
   assign addr[1] = b_addr;
   assign a_dout = dout[0];
   assign b_dout = dout[1];
   assign {b_valid, a_valid} = valid;
   assign {b_coll, a_coll} = coll;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state <= S_RESET;
         cnt <= '0;
         init_busy <= CLEAR_ON_RESET != 0;
         c_drop <= 1'b0;
      end else begin
         c_drop <= state == S_CLEAR && c_we;
         case (state)
            S_RESET: state <= CLEAR_ON_RESET != 0 ? S_CLEAR : S_READY;
            S_CLEAR: begin
               cnt <= cnt + 1'b1;
               if (&cnt) begin
                  state <= S_READY;
                  init_busy <= 1'b0;
               end
            end
            S_READY: if (clr) begin
               state <= S_CLEAR;
               init_busy <= 1'b1;
            end
            default: state <= S_RESET;
         endcase
      end
   // contents survive resetn; only the clear engine initialises them
   always_ff @(posedge clk)
      if (state == S_CLEAR) mem[cnt] <= INIT_VALUE;
      else if (wr) mem[c_addr] <= c_din;
   for (genvar i = 0; i < 2; i++) begin : g_port
      localparam int L = i == 0 ? A_LATENCY : B_LATENCY;
      assign hit[i] = re[i] && wr && addr[i] == c_addr;
      assign raw[i] = COLLISION_MODE != 0 && hit[i] ? c_din : mem[addr[i]];
      if (L == 0) begin : g_async
         assign dout[i] = raw[i];
         assign valid[i] = re[i];
         assign coll[i] = hit[i];
      end else begin : g_sync
         logic [DATA_WIDTH-1:0] d1;
         logic v1, c1;
         always_ff @(posedge clk or negedge resetn)
            if (!resetn) begin
               d1 <= '0;
               v1 <= 1'b0;
               c1 <= 1'b0;
            end else begin
               v1 <= re[i];
               c1 <= hit[i];
               if (re[i]) d1 <= raw[i];
            end
         if (L == 1) begin : g_l1
            assign dout[i] = d1;
            assign valid[i] = v1;
            assign coll[i] = c1;
         end else begin : g_l2
            logic [DATA_WIDTH-1:0] d2;
            logic v2, c2;
            always_ff @(posedge clk or negedge resetn)
               if (!resetn) begin
                  d2 <= '0;
                  v2 <= 1'b0;
                  c2 <= 1'b0;
               end else begin
                  v2 <= v1;
                  c2 <= c1;
                  if (v1) d2 <= d1;
               end
            assign dout[i] = d2;
            assign valid[i] = v2;
            assign coll[i] = c2;
         end
      end
   end
endmodule

// File: tb/tb_usram_triport_ctrl.sv
// tb_usram_triport_ctrl: two configurations driven in lockstep against a spec-level memory/event model.
module tb_usram_triport_ctrl;
   localparam int DW = 18, AW = 6, D = 64, H = 2048;
   localparam logic [DW-1:0] INIT = 18'h155;
   logic clk = 1'b0, resetn, clr, c_we, a_re, b_re;
   logic [AW-1:0] c_addr, a_addr, b_addr;
   logic [DW-1:0] c_din;
   logic busy0, busy1, drop0, drop1;
   logic [DW-1:0] ad0, bd0, ad1, bd1;
   logic av0, bv0, ac0, bc0, av1, bv1, ac1, bc1;
   int n_chk = 0, n_fail = 0, drops = 0, n = 0, clear_left = 0;
   bit rst_phase = 1'b0;
   logic [DW-1:0] mem [D];
   bit h_ra [H], h_rb [H], h_ca [H], h_cb [H];
   logic [DW-1:0] h_a0 [H], h_b0 [H], h_b1 [H];

   always #5 clk = ~clk;

   usram_triport_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .A_LATENCY(1), .B_LATENCY(2),
      .COLLISION_MODE(0), .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)) u0 (
      .clk(clk), .resetn(resetn), .clr(clr), .init_busy(busy0),
      .c_we(c_we), .c_addr(c_addr), .c_din(c_din), .c_drop(drop0),
      .a_re(a_re), .a_addr(a_addr), .a_dout(ad0), .a_valid(av0), .a_coll(ac0),
      .b_re(b_re), .b_addr(b_addr), .b_dout(bd0), .b_valid(bv0), .b_coll(bc0));

   usram_triport_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .A_LATENCY(0), .B_LATENCY(1),
      .COLLISION_MODE(1), .CLEAR_ON_RESET(1), .INIT_VALUE(INIT)) u1 (
      .clk(clk), .resetn(resetn), .clr(clr), .init_busy(busy1),
      .c_we(c_we), .c_addr(c_addr), .c_din(c_din), .c_drop(drop1),
      .a_re(a_re), .a_addr(a_addr), .a_dout(ad1), .a_valid(av1), .a_coll(ac1),
      .b_re(b_re), .b_addr(b_addr), .b_dout(bd1), .b_valid(bv1), .b_coll(bc1));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // newest returned word at or before event idx; sel 0 = A old-data, 1 = B old-data, 2 = B forwarded
   function automatic logic [DW-1:0] last(input int sel, input int idx);
      for (int k = idx; k >= 0; k--)
         if (sel == 0 ? h_ra[k] : h_rb[k]) return sel == 0 ? h_a0[k] : sel == 1 ? h_b0[k] : h_b1[k];
      return '0;
   endfunction

   task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic ar, input logic [AW-1:0] aa, input logic br,
                      input logic [AW-1:0] ba, input logic cl);
      bit rdy, ca, cb, dexp;
      int e;
      c_we = we; c_addr = wa; c_din = wd; a_re = ar; a_addr = aa; b_re = br; b_addr = ba; clr = cl;
      #1;
      e = n;
      rdy = !rst_phase && clear_left == 0;
      ca = rdy && ar && we && aa == wa;
      cb = rdy && br && we && ba == wa;
      h_ra[e] = rdy && ar; h_rb[e] = rdy && br; h_ca[e] = ca; h_cb[e] = cb;
      h_a0[e] = mem[aa]; h_b0[e] = mem[ba]; h_b1[e] = cb ? wd : mem[ba];
      dexp = !rst_phase && clear_left > 0 && we;
      check("u1_a_valid_async", av1, rdy && ar);
      check("u1_a_coll_async", ac1, ca);
      if (rdy) check("u1_a_dout_async", ad1, ca ? wd : mem[aa]);
      @(posedge clk);
      #1;
      if (rst_phase) begin
         rst_phase = 1'b0;
         clear_left = D;
      end else if (clear_left > 0) begin
         mem[D - clear_left] = INIT;
         clear_left--;
      end else begin
         if (we) mem[wa] = wd;
         if (cl) clear_left = D;
      end
      n = e + 1;
      if (drop0) drops++;
      check("u0_busy", busy0, clear_left > 0);
      check("u1_busy", busy1, clear_left > 0);
      check("u0_drop", drop0, dexp);
      check("u1_drop", drop1, dexp);
      check("u0_a_valid", av0, h_ra[e]);
      check("u0_a_coll", ac0, h_ca[e]);
      check("u0_a_dout", ad0, last(0, e));
      check("u0_b_valid", bv0, e >= 1 ? h_rb[e-1] : 1'b0);
      check("u0_b_coll", bc0, e >= 1 ? h_cb[e-1] : 1'b0);
      check("u0_b_dout", bd0, last(1, e - 1));
      check("u1_b_valid", bv1, h_rb[e]);
      check("u1_b_coll", bc1, h_cb[e]);
      check("u1_b_dout", bd1, last(2, e));
   endtask

   task automatic do_reset();
      a_re = 1'b1; b_re = 1'b1;
      resetn = 1'b0;
      #2;
      check("rst_busy0", busy0, 1);
      check("rst_busy1", busy1, 1);
      check("rst_drop", drop0, 0);
      check("rst_valids", {av0, bv0, av1, bv1}, 0);
      check("rst_colls", {ac0, bc0, ac1, bc1}, 0);
      check("rst_douts", {ad0 | bd0 | bd1}, 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      rst_phase = 1'b1;
      clear_left = 0;
      n = 0;
   endtask

   task automatic busy_loop(input bit drop_write);
      int cnt = 0;
      bit done = 1'b0;
      drops = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         cyc(drop_write && i == 11, 6'd7, 18'h3FFFF, 1'b1, 6'($urandom), 1'b1, 6'($urandom), 1'b0);
         if (busy0) cnt++;
         else done = 1'b1;
      end
      check("busy_cycles", cnt, 64);
      check("drop_pulses", drops, drop_write ? 1 : 0);
   endtask

   initial begin
      {clr, c_we, a_re, b_re} = '0;
      c_addr = '0; a_addr = '0; b_addr = '0; c_din = '0;
      resetn = 1'b1;
      #1;
      do_reset();
      busy_loop(1'b1);
      cyc(0, 0, 0, 1, 6'd0, 1, 6'd31, 0);
      check("rd_addr0", ad0, INIT);
      cyc(0, 0, 0, 1, 6'd63, 1, 6'd7, 0);
      check("rd_addr63", ad0, INIT);
      check("rd_addr31", bd0, INIT);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      check("rd_dropped_addr7", bd0, INIT);
      cyc(1, 6'd5, 18'h3ABCD, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 6'd5, 1, 6'd5, 0);
      check("wr5_a_dout", ad0, 18'h3ABCD);
      check("wr5_a_valid", av0, 1);
      check("wr5_a_coll", ac0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      check("wr5_b_dout", bd0, 18'h3ABCD);
      check("wr5_b_valid", bv0, 1);
      check("wr5_b_coll", bc0, 0);
      cyc(1, 6'd9, 18'h2FFFF, 0, 0, 0, 0, 0);
      cyc(1, 6'd9, 18'h00001, 1, 6'd9, 1, 6'd9, 0);
      check("coll_mode0_dout", ad0, 18'h2FFFF);
      check("coll_mode0_flag", ac0, 1);
      check("coll_mode1_dout", bd1, 18'h00001);
      check("coll_mode1_flag", bc1, 1);
      for (int i = 0; i < 4; i++) cyc(1, 6'(i), 18'(32'h100 + 3 * i), 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 6'(i), 0, 0, 0);
      for (int i = 0; i < 300; i++)
         cyc(1'($urandom), 6'($urandom_range(0, 7)), 18'($urandom), 1'($urandom),
             6'($urandom_range(0, 7)), 1'($urandom), 6'($urandom_range(0, 7)), 1'b0);
      cyc(0, 0, 0, 1, 6'd5, 1, 6'd9, 1);
      for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1, 6'($urandom), 1, 6'($urandom), 0);
      do_reset();
      busy_loop(1'b0);
      for (int i = 0; i < D; i++) cyc(0, 0, 0, 1, 6'(i), 1, 6'(D - 1 - i), 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
